// File: rtl/cordic_quadrant_prerot_pipe.sv
// -----------------------------------------------------------------------------
// cordic_quadrant_prerot_pipe
//
// Quadrant pre-rotation stage ahead of the CORDIC core in the QAM-16 receiver.
// It folds (x, y, z) into the CORDIC convergence range using exact
// +/-90 and 180 degree swaps and negations. The stage is a two-deep pipeline
// with a valid/ready handshake on both sides.
//
//   rotation mode  (mode = 0): the quadrant comes from the angle z_in, and the
//                              quadrant offset is subtracted from z.
//   vectoring mode (mode = 1): the quadrant comes from the signs of x and y, and
//                              the applied rotation is added to the running
//                              angle z, modulo TWO_PI.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   in_valid/ready upstream handshake; in_ready does not depend on in_valid
//   mode           0 = rotation, 1 = vectoring; captured with each sample
//   x_in, y_in     signed WIDTH_WIRE-bit vector components
//   z_in           unsigned WIDTH-bit phase in [0, TWO_PI)
//   out_valid/ready downstream handshake; outputs hold while stalled
//   x_out, y_out   pre-rotated vector
//   z_out          residual (rotation) or accumulated (vectoring) angle
//   quad_out       0 = none, 1 = +90, 2 = 180, 3 = -90
//   sat_out        a negation in this sample clipped at the positive limit
//   range_err      rotation-mode z_in >= TWO_PI; the sample passes unchanged
//   sat_count      saturating count of transferred samples with sat_out = 1
//   clr_sat_cnt    synchronous clear of sat_count; wins over an increment
// -----------------------------------------------------------------------------
module cordic_quadrant_prerot_pipe #(
   parameter int unsigned WIDTH         = 16,
   parameter int unsigned WIDTH_WIRE    = 18,
   parameter int unsigned PI_HALF       = 6433,
   parameter int unsigned PI            = 12867,
   parameter int unsigned THREE_PI_HALF = 19301,
   parameter int unsigned TWO_PI        = 25735,
   parameter int unsigned CNT_WIDTH     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         mode,
   input  logic signed [WIDTH_WIRE-1:0] x_in,
   input  logic signed [WIDTH_WIRE-1:0] y_in,
   input  logic        [WIDTH-1:0]      z_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [WIDTH_WIRE-1:0] x_out,
   output logic signed [WIDTH_WIRE-1:0] y_out,
   output logic        [WIDTH-1:0]      z_out,
   output logic        [1:0]            quad_out,
   output logic                         sat_out,
   output logic                         range_err,
   output logic        [CNT_WIDTH-1:0]  sat_count,
   input  logic                         clr_sat_cnt
);

   // z comparisons and the vectoring-mode sum use one extra bit so that
   // z + THREE_PI_HALF cannot overflow before the modulo subtract.
   localparam int unsigned ZW = WIDTH + 1;

   localparam logic [ZW-1:0]    PI_HALF_Z       = ZW'(PI_HALF);
   localparam logic [ZW-1:0]    PI_Z            = ZW'(PI);
   localparam logic [ZW-1:0]    THREE_PI_HALF_Z = ZW'(THREE_PI_HALF);
   localparam logic [ZW-1:0]    TWO_PI_Z        = ZW'(TWO_PI);

   localparam logic [WIDTH-1:0] PI_HALF_W       = WIDTH'(PI_HALF);
   localparam logic [WIDTH-1:0] PI_W            = WIDTH'(PI);
   localparam logic [WIDTH-1:0] THREE_PI_HALF_W = WIDTH'(THREE_PI_HALF);

   localparam logic [WIDTH_WIRE-1:0] XMIN = {1'b1, {(WIDTH_WIRE-1){1'b0}}};
   localparam logic [WIDTH_WIRE-1:0] XMAX = ~XMIN;

   typedef enum logic [1:0] {
      Q_NONE = 2'd0,
      Q_P90  = 2'd1,
      Q_180  = 2'd2,
      Q_M90  = 2'd3
   } quad_e;

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   logic s1_valid_q;
   logic s2_valid_q;
   logic s2_adv;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_adv;

   // ---------------------------------------------------------------------------
   // S1: quadrant decode and input capture
   // ---------------------------------------------------------------------------
   quad_e                  s1_quad_d;
   logic                   s1_rerr_d;
   logic [ZW-1:0]          z_ext;

   always_comb begin
      s1_quad_d = Q_NONE;
      s1_rerr_d = 1'b0;
      z_ext     = {1'b0, z_in};
      if (mode) begin
         // Vectoring: fold the left half-plane onto the right half-plane.
         if (x_in[WIDTH_WIRE-1]) begin
            s1_quad_d = y_in[WIDTH_WIRE-1] ? Q_P90 : Q_M90;
         end
      end else begin
         if (z_ext >= TWO_PI_Z) begin
            s1_rerr_d = 1'b1;
         end else if (z_ext >= THREE_PI_HALF_Z) begin
            s1_quad_d = Q_M90;
         end else if (z_ext >= PI_Z) begin
            s1_quad_d = Q_180;
         end else if (z_ext >= PI_HALF_Z) begin
            s1_quad_d = Q_P90;
         end
      end
   end

   logic                         s1_mode_q;
   logic signed [WIDTH_WIRE-1:0] s1_x_q;
   logic signed [WIDTH_WIRE-1:0] s1_y_q;
   logic        [WIDTH-1:0]      s1_z_q;
   quad_e                        s1_quad_q;
   logic                         s1_rerr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_z_q     <= '0;
         s1_quad_q  <= Q_NONE;
         s1_rerr_q  <= 1'b0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_mode_q <= mode;
            s1_x_q    <= x_in;
            s1_y_q    <= y_in;
            s1_z_q    <= z_in;
            s1_quad_q <= s1_quad_d;
            s1_rerr_q <= s1_rerr_d;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // S2: swap / saturating negate and angle update
   // ---------------------------------------------------------------------------
   logic signed [WIDTH_WIRE-1:0] neg_x;
   logic signed [WIDTH_WIRE-1:0] neg_y;
   logic                         neg_x_sat;
   logic                         neg_y_sat;

   always_comb begin
      neg_x_sat = (s1_x_q == XMIN);
      neg_y_sat = (s1_y_q == XMIN);
      neg_x     = neg_x_sat ? XMAX : ('0 - s1_x_q);
      neg_y     = neg_y_sat ? XMAX : ('0 - s1_y_q);
   end

   logic signed [WIDTH_WIRE-1:0] s2_x_d;
   logic signed [WIDTH_WIRE-1:0] s2_y_d;
   logic        [WIDTH-1:0]      s2_z_d;
   logic                         s2_sat_d;
   logic        [ZW-1:0]         z_add;
   logic        [ZW-1:0]         z_sum;

   always_comb begin
      s2_x_d   = s1_x_q;
      s2_y_d   = s1_y_q;
      s2_sat_d = 1'b0;
      case (s1_quad_q)
         Q_P90: begin
            s2_x_d   = neg_y;
            s2_y_d   = s1_x_q;
            s2_sat_d = neg_y_sat;
         end
         Q_180: begin
            s2_x_d   = neg_x;
            s2_y_d   = neg_y;
            s2_sat_d = neg_x_sat || neg_y_sat;
         end
         Q_M90: begin
            s2_x_d   = s1_y_q;
            s2_y_d   = neg_x;
            s2_sat_d = neg_x_sat;
         end
         default: ;
      endcase
   end

   // The swap operations are shared by both modes; only the angle update
   // differs: rotation removes the quadrant offset, vectoring accumulates the
   // applied rotation (Q_M90 adds pi/2, Q_P90 adds 3pi/2).
   always_comb begin
      z_add = '0;
      if (s1_quad_q == Q_M90) begin
         z_add = PI_HALF_Z;
      end else if (s1_quad_q == Q_P90) begin
         z_add = THREE_PI_HALF_Z;
      end
      z_sum  = {1'b0, s1_z_q} + z_add;
      s2_z_d = s1_z_q;
      if (s1_mode_q) begin
         if (s1_quad_q != Q_NONE) begin
            s2_z_d = (z_sum >= TWO_PI_Z) ? WIDTH'(z_sum - TWO_PI_Z) : WIDTH'(z_sum);
         end
      end else begin
         case (s1_quad_q)
            Q_P90:   s2_z_d = s1_z_q - PI_HALF_W;
            Q_180:   s2_z_d = s1_z_q - PI_W;
            Q_M90:   s2_z_d = s1_z_q - THREE_PI_HALF_W;
            default: s2_z_d = s1_z_q;
         endcase
      end
   end

   logic signed [WIDTH_WIRE-1:0] s2_x_q;
   logic signed [WIDTH_WIRE-1:0] s2_y_q;
   logic        [WIDTH-1:0]      s2_z_q;
   quad_e                        s2_quad_q;
   logic                         s2_sat_q;
   logic                         s2_rerr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_x_q     <= '0;
         s2_y_q     <= '0;
         s2_z_q     <= '0;
         s2_quad_q  <= Q_NONE;
         s2_sat_q   <= 1'b0;
         s2_rerr_q  <= 1'b0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_x_q    <= s2_x_d;
            s2_y_q    <= s2_y_d;
            s2_z_q    <= s2_z_d;
            s2_quad_q <= s1_quad_q;
            s2_sat_q  <= s2_sat_d;
            s2_rerr_q <= s1_rerr_q;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Saturation event counter
   // ---------------------------------------------------------------------------
   logic [CNT_WIDTH-1:0] sat_cnt_q;
   logic [CNT_WIDTH-1:0] sat_cnt_d;
   logic                 sat_evt;

   always_comb begin
      sat_evt   = s2_valid_q && out_ready && s2_sat_q;
      sat_cnt_d = sat_cnt_q;
      if (clr_sat_cnt) begin
         sat_cnt_d = '0;
      end else if (sat_evt && (sat_cnt_q != '1)) begin
         sat_cnt_d = sat_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt_q <= '0;
      end else begin
         sat_cnt_q <= sat_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign out_valid = s2_valid_q;
   assign x_out     = s2_x_q;
   assign y_out     = s2_y_q;
   assign z_out     = s2_z_q;
   assign quad_out  = s2_quad_q;
   assign sat_out   = s2_sat_q;
   assign range_err = s2_rerr_q;
   assign sat_count = sat_cnt_q;

endmodule
